udma_filter_tx_datafetch: RTL and testbench

Read-side DMA engine of the uDMA filter block: fetches operand data from L2 over a uDMA TX channel following a linear, 2D-row or 2D-column address pattern and presents it as a ready/valid stream to the filter datapath. It is the source-side counterpart of the filter's RX data-out engine and shares the same pattern configuration (start address, datasize, mode, len0/len1/len2). An internal FIFO absorbs read-response latency. Request issue is credit-limited, so responses are never dropped.

---
 rtl/udma_filter_tx_datafetch_if.sv | 63 ++++++
 rtl/udma_filter_tx_datafetch.sv | 238 +++++++++++++++++++++++
 tb/tb_udma_filter_tx_datafetch.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/udma_filter_tx_datafetch_if.sv
// ---------------------------------------------------------------------------
// udma_filter_tx_datafetch_if
// Bundles the uDMA TX read channel and the outgoing data stream of the filter
// TX data-fetch engine. Signal names keep the engine-side direction suffix.
//   master : the fetch engine (drives requests, consumes responses, sources
//            the stream)
//   slave  : the environment (L2 channel + stream consumer)
// Signals:
//   tx_ch_req_o / tx_ch_addr_o / tx_ch_datasize_o : read request
//   tx_ch_gnt_i                                  : request accepted
//   tx_ch_valid_i / tx_ch_data_i                 : in-order read response
//   stream_data_o / stream_valid_o / stream_ready_i : fetched data stream
//   stream_last_o : final-element flag (only with UDMA_FILTER_TX_STREAM_LAST_EN)
// ---------------------------------------------------------------------------
interface udma_filter_tx_datafetch_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned L2_AWIDTH_NOAL = 15
) ();

  logic                      tx_ch_req_o;
  logic [L2_AWIDTH_NOAL-1:0] tx_ch_addr_o;
  logic [1:0]                tx_ch_datasize_o;
  logic                      tx_ch_gnt_i;
  logic                      tx_ch_valid_i;
  logic [DATA_WIDTH-1:0]     tx_ch_data_i;
  logic [DATA_WIDTH-1:0]     stream_data_o;
  logic                      stream_valid_o;
  logic                      stream_ready_i;
`ifdef UDMA_FILTER_TX_STREAM_LAST_EN
  logic                      stream_last_o;
`endif

  modport master (
    output tx_ch_req_o,
    output tx_ch_addr_o,
    output tx_ch_datasize_o,
    input  tx_ch_gnt_i,
    input  tx_ch_valid_i,
    input  tx_ch_data_i,
    output stream_data_o,
    output stream_valid_o,
`ifdef UDMA_FILTER_TX_STREAM_LAST_EN
    output stream_last_o,
`endif
    input  stream_ready_i
  );

  modport slave (
    input  tx_ch_req_o,
    input  tx_ch_addr_o,
    input  tx_ch_datasize_o,
    output tx_ch_gnt_i,
    output tx_ch_valid_i,
    output tx_ch_data_i,
    input  stream_data_o,
    input  stream_valid_o,
`ifdef UDMA_FILTER_TX_STREAM_LAST_EN
    input  stream_last_o,
`endif
    output stream_ready_i
  );

endinterface

// File: rtl/udma_filter_tx_datafetch.sv
// ---------------------------------------------------------------------------
// udma_filter_tx_datafetch
// Read-side DMA engine of the uDMA filter. Walks a linear, 2D-row or 2D-column
// address pattern, issues credit-limited reads on the uDMA TX channel and
// buffers the in-order responses in a small FIFO that feeds a ready/valid
// stream.
// Ports:
//   clk_i, resetn_i         : clock, asynchronous active-low reset
//   bus_if (master)         : TX read channel + output stream
//   cmd_start_i             : start pulse (ignored unless idle)
//   cmd_done_o              : one-cycle completion pulse
//   busy_o                  : engine not idle
//   cfg_start_addr_i        : first byte address (latched at start)
//   cfg_datasize_i          : 00 byte, 01 half, 10 word, 11 no increment
//   cfg_mode_i              : 0 linear, 1 2D row, 2 2D col, 3 linear (latched)
//   cfg_len0/1/2_i          : inner count-1, outer count-1, stride in bytes
// Optional feature macro: UDMA_FILTER_TX_STREAM_LAST_EN adds stream_last_o,
// flagging the final element of a transfer via a tag bit stored per FIFO entry.
// ---------------------------------------------------------------------------
module udma_filter_tx_datafetch #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned L2_AWIDTH_NOAL = 15,
  parameter int unsigned BUFFER_DEPTH   = 4,
  parameter int unsigned TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,
  udma_filter_tx_datafetch_if.master bus_if,
  input  logic                      cmd_start_i,
  output logic                      cmd_done_o,
  output logic                      busy_o,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
  input  logic [1:0]                cfg_datasize_i,
  input  logic [1:0]                cfg_mode_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len2_i
);

  localparam int unsigned CntW = $clog2(BUFFER_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(BUFFER_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e                    r_state, w_state_next;
  logic [1:0]                r_mode;
  logic [L2_AWIDTH_NOAL-1:0] r_start, w_start_next;
  logic [L2_AWIDTH_NOAL-1:0] r_ptr, w_ptr_next;
  logic [TRANS_SIZE-1:0]     r_w, w_w_next;
  logic [TRANS_SIZE-1:0]     r_l, w_l_next;
  logic [CntW-1:0]           r_outstanding;

  logic [DATA_WIDTH-1:0]     r_mem [BUFFER_DEPTH];
  logic [PtrW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]           r_count;

  logic [L2_AWIDTH_NOAL-1:0] w_inc, w_stride;
  logic                      w_w_end, w_l_end;
  logic                      w_credit, w_req, w_gnt, w_push, w_pop;
  logic                      w_last_gnt, w_done;

  always_comb begin
    unique case (cfg_datasize_i)
      2'b00:   w_inc = L2_AWIDTH_NOAL'(1);
      2'b01:   w_inc = L2_AWIDTH_NOAL'(2);
      2'b10:   w_inc = L2_AWIDTH_NOAL'(4);
      default: w_inc = '0;
    endcase
  end

  assign w_stride = L2_AWIDTH_NOAL'(cfg_len2_i);
  assign w_w_end  = (r_w == cfg_len0_i);
  assign w_l_end  = (r_l == cfg_len1_i);

  // Outstanding reads plus buffered data never exceed the FIFO depth, so every
  // response has a slot waiting for it.
  assign w_credit = (int'(r_outstanding) + int'(r_count)) < int'(BUFFER_DEPTH);
  assign w_gnt    = w_req & bus_if.tx_ch_gnt_i;
  // A response with nothing outstanding is a leftover from before reset.
  assign w_push   = bus_if.tx_ch_valid_i & (r_outstanding != '0);
  assign w_pop    = bus_if.stream_valid_o & bus_if.stream_ready_i;

  always_comb begin
    w_state_next = r_state;
    w_start_next = r_start;
    w_ptr_next   = r_ptr;
    w_w_next     = r_w;
    w_l_next     = r_l;
    w_req        = 1'b0;
    w_last_gnt   = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (cmd_start_i) begin
          w_state_next = StFetch;
          w_start_next = cfg_start_addr_i;
          w_ptr_next   = cfg_start_addr_i;
          w_w_next     = '0;
          w_l_next     = '0;
        end
      end
      StFetch: begin
        w_req = w_credit;
        if (w_gnt) begin
          case (r_mode)
            2'd1: begin
              if (w_w_end && w_l_end) begin
                w_last_gnt = 1'b1;
              end else if (w_w_end) begin
                w_w_next     = '0;
                w_l_next     = r_l + TRANS_SIZE'(1);
                w_start_next = r_start + w_stride;
                w_ptr_next   = r_start + w_stride;
              end else begin
                w_w_next   = r_w + TRANS_SIZE'(1);
                w_ptr_next = r_ptr + w_inc;
              end
            end
            2'd2: begin
              if (w_w_end && w_l_end) begin
                w_last_gnt = 1'b1;
              end else if (w_l_end) begin
                w_l_next     = '0;
                w_w_next     = r_w + TRANS_SIZE'(1);
                w_start_next = r_start + w_inc;
                w_ptr_next   = r_start + w_inc;
              end else begin
                w_l_next   = r_l + TRANS_SIZE'(1);
                w_ptr_next = r_ptr + w_stride;
              end
            end
            default: begin
              if (w_w_end) begin
                w_last_gnt = 1'b1;
              end else begin
                w_w_next   = r_w + TRANS_SIZE'(1);
                w_ptr_next = r_ptr + w_inc;
              end
            end
          endcase
          if (w_last_gnt) w_state_next = StDrain;
        end
      end
      StDrain: begin
        if ((r_outstanding == '0) && !bus_if.tx_ch_valid_i) begin
          w_state_next = StIdle;
          w_done       = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= StIdle;
      r_mode  <= '0;
      r_start <= '0;
      r_ptr   <= '0;
      r_w     <= '0;
      r_l     <= '0;
    end else begin
      r_state <= w_state_next;
      r_start <= w_start_next;
      r_ptr   <= w_ptr_next;
      r_w     <= w_w_next;
      r_l     <= w_l_next;
      if (r_state == StIdle && cmd_start_i) r_mode <= cfg_mode_i;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_outstanding <= '0;
    end else if (w_gnt && !w_push) begin
      r_outstanding <= r_outstanding + CntW'(1);
    end else if (!w_gnt && w_push) begin
      r_outstanding <= r_outstanding - CntW'(1);
    end
  end

  // Response FIFO
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < int'(BUFFER_DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus_if.tx_ch_data_i;
        r_wr_ptr <= (r_wr_ptr == PtrW'(BUFFER_DEPTH - 1)) ? '0 : r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PtrW'(BUFFER_DEPTH - 1)) ? '0 : r_rd_ptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

`ifdef UDMA_FILTER_TX_STREAM_LAST_EN
  logic r_tag [BUFFER_DEPTH];
  logic r_last_pending;

  // Responses are in order and no grants follow the last one, so the response
  // arriving while exactly one read is outstanding is the final element.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < int'(BUFFER_DEPTH); i++) r_tag[i] <= 1'b0;
      r_last_pending <= 1'b0;
    end else begin
      if (w_push) begin
        r_tag[r_wr_ptr] <= r_last_pending && (r_outstanding == CntW'(1));
      end
      if (w_last_gnt) begin
        r_last_pending <= 1'b1;
      end else if (w_done) begin
        r_last_pending <= 1'b0;
      end
    end
  end

  assign bus_if.stream_last_o = bus_if.stream_valid_o & r_tag[r_rd_ptr];
`endif

  assign bus_if.tx_ch_req_o      = w_req;
  assign bus_if.tx_ch_addr_o     = r_ptr;
  assign bus_if.tx_ch_datasize_o = cfg_datasize_i;
  assign bus_if.stream_valid_o   = (r_count != '0);
  assign bus_if.stream_data_o    = r_mem[r_rd_ptr];
  assign cmd_done_o              = w_done;
  assign busy_o                  = (r_state != StIdle);

endmodule

// File: tb/tb_udma_filter_tx_datafetch.sv
module tb_udma_filter_tx_datafetch;
  localparam int DW = 32;
  localparam int AW = 15;
  localparam int BD = 4;
  localparam int TS = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  udma_filter_tx_datafetch_if #(.DATA_WIDTH(DW), .L2_AWIDTH_NOAL(AW)) bus ();

  logic          cmd_start, cmd_done, busy;
  logic [AW-1:0] cfg_start_addr;
  logic [1:0]    cfg_datasize, cfg_mode;
  logic [TS-1:0] cfg_len0, cfg_len1, cfg_len2;

  udma_filter_tx_datafetch #(
    .DATA_WIDTH    (DW),
    .L2_AWIDTH_NOAL(AW),
    .BUFFER_DEPTH  (BD),
    .TRANS_SIZE    (TS)
  ) dut (
    .clk_i           (clk),
    .resetn_i        (resetn),
    .bus_if          (bus),
    .cmd_start_i     (cmd_start),
    .cmd_done_o      (cmd_done),
    .busy_o          (busy),
    .cfg_start_addr_i(cfg_start_addr),
    .cfg_datasize_i  (cfg_datasize),
    .cfg_mode_i      (cfg_mode),
    .cfg_len0_i      (cfg_len0),
    .cfg_len1_i      (cfg_len1),
    .cfg_len2_i      (cfg_len2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int lat = 2;
  bit gnt_rand = 1'b0;
  int ready_mode = 0;  // 0 always ready, 1 random, 2 held low
  int done_cnt = 0;
  int gidx = 0;
  logic [AW-1:0] exp_addr[$];
  int            resp_due[$];
  logic [DW-1:0] resp_dat[$];
  logic [DW-1:0] exp_stream[$];
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference address sequence straight from the pattern definition.
  task automatic build_model(input int mode, input int ds, input int start,
                             input int l0, input int l1, input int l2);
    int inc;
    inc = (ds == 0) ? 1 : (ds == 1) ? 2 : (ds == 2) ? 4 : 0;
    exp_addr.delete();
    if (mode == 1) begin
      for (int l = 0; l <= l1; l++)
        for (int w = 0; w <= l0; w++) exp_addr.push_back(AW'(start + l * l2 + w * inc));
    end else if (mode == 2) begin
      for (int w = 0; w <= l0; w++)
        for (int l = 0; l <= l1; l++) exp_addr.push_back(AW'(start + w * inc + l * l2));
    end else begin
      for (int w = 0; w <= l0; w++) exp_addr.push_back(AW'(start + w * inc));
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, ":req"}, bus.tx_ch_req_o, 0);
    chk({tag, ":addr"}, bus.tx_ch_addr_o, 0);
    chk({tag, ":done"}, cmd_done, 0);
    chk({tag, ":busy"}, busy, 0);
    chk({tag, ":svalid"}, bus.stream_valid_o, 0);
    chk({tag, ":sdata"}, bus.stream_data_o, 0);
`ifdef UDMA_FILTER_TX_STREAM_LAST_EN
    chk({tag, ":slast"}, bus.stream_last_o, 0);
`endif
  endtask

  // One clock cycle: drive just after the edge, observe mid-cycle.
  task automatic step();
    logic [DW-1:0] d;
    logic          exp_last;
    @(posedge clk);
    #1;
    cyc++;
    if (resp_due.size() > 0 && resp_due[0] == cyc) begin
      void'(resp_due.pop_front());
      bus.tx_ch_valid_i = 1'b1;
      bus.tx_ch_data_i  = resp_dat.pop_front();
    end else begin
      bus.tx_ch_valid_i = 1'b0;
      bus.tx_ch_data_i  = $urandom;
    end
    bus.tx_ch_gnt_i    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.stream_ready_i = (ready_mode == 0) ? 1'b1 :
                         (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    #4;
    if (prev_stall) chk("addr_hold", bus.tx_ch_addr_o, prev_addr);
    prev_stall = bus.tx_ch_req_o && !bus.tx_ch_gnt_i;
    prev_addr  = bus.tx_ch_addr_o;
    if (bus.tx_ch_req_o && bus.tx_ch_gnt_i) begin
      if (gidx < exp_addr.size()) chk("req_addr", bus.tx_ch_addr_o, exp_addr[gidx]);
      else chk("req_count", gidx + 1, exp_addr.size());
      chk("datasize", bus.tx_ch_datasize_o, cfg_datasize);
      gidx++;
      d = $urandom;
      resp_due.push_back(cyc + lat);
      resp_dat.push_back(d);
      exp_stream.push_back(d);
    end
    if (bus.stream_valid_o && bus.stream_ready_i) begin
      exp_last = (exp_stream.size() == 1) && (gidx == exp_addr.size()) && (resp_due.size() == 0);
      if (exp_stream.size() > 0) chk("stream_data", bus.stream_data_o, exp_stream.pop_front());
      else chk("stream_extra_beat", bus.stream_valid_o, 1'b0);
`ifdef UDMA_FILTER_TX_STREAM_LAST_EN
      chk("stream_last", bus.stream_last_o, exp_last);
`else
      if (exp_last) d = '0;
`endif
    end
    if (cmd_done) begin
      done_cnt++;
      chk("done_all_granted", gidx, exp_addr.size());
      chk("done_no_pending", resp_due.size(), 0);
    end
  endtask

  task automatic run_xfer(input string name, input int mode, input int ds, input int start,
                          input int l0, input int l1, input int l2, input bit gr,
                          input int rm, input int lt, input bit poke);
    build_model(mode, ds, start, l0, l1, l2);
    gidx = 0; done_cnt = 0; lat = lt; gnt_rand = gr; ready_mode = rm;
    cfg_mode = 2'(mode); cfg_datasize = 2'(ds); cfg_start_addr = AW'(start);
    cfg_len0 = TS'(l0); cfg_len1 = TS'(l1); cfg_len2 = TS'(l2);
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    chk({name, ":busy"}, busy, 1);
    chk({name, ":first_req"}, bus.tx_ch_req_o, 1);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      if (poke && k == 2) begin
        cmd_start = 1'b1;
        cfg_start_addr = AW'($urandom);
      end
      step();
      cmd_start = 1'b0;
      if (ready_mode == 2 && k == 20) begin
        chk({name, ":bp_grants"}, gidx, BD);
        chk({name, ":bp_req"}, bus.tx_ch_req_o, 0);
        ready_mode = 0;
      end
    end
    chk({name, ":done_seen"}, done_cnt, 1);
    ready_mode = 0;
    for (int k = 0; k < 50 && exp_stream.size() > 0; k++) step();
    chk({name, ":beats_left"}, exp_stream.size(), 0);
    chk({name, ":grants"}, gidx, exp_addr.size());
    step();
    step();
    chk({name, ":idle"}, busy, 0);
    chk({name, ":one_done"}, done_cnt, 1);
    chk({name, ":req_off"}, bus.tx_ch_req_o, 0);
    chk({name, ":fifo_empty"}, bus.stream_valid_o, 0);
  endtask

  initial begin
    cmd_start = 1'b0; cfg_start_addr = '0; cfg_datasize = '0; cfg_mode = '0;
    cfg_len0 = '0; cfg_len1 = '0; cfg_len2 = '0;
    bus.tx_ch_gnt_i = 1'b0; bus.tx_ch_valid_i = 1'b0; bus.tx_ch_data_i = '0;
    bus.stream_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset");
    resetn = 1'b1;

    run_xfer("linear", 0, 2, 'h100, 3, 0, 0, 1'b0, 0, 2, 1'b0);
    run_xfer("row2d", 1, 0, 'h0, 1, 2, 'h10, 1'b0, 0, 2, 1'b0);
    run_xfer("col2d", 2, 1, 'h40, 1, 1, 'h8, 1'b0, 0, 3, 1'b0);
    run_xfer("backpressure", 0, 2, 'h200, 9, 0, 0, 1'b0, 2, 2, 1'b0);
    run_xfer("wrap", 0, 2, 'h7FFE, 1, 0, 0, 1'b0, 0, 1, 1'b0);
    run_xfer("busy_start", 0, 0, 'h300, 5, 0, 0, 1'b1, 1, 2, 1'b1);
    run_xfer("single", 1, 2, 'h10, 0, 0, 'h20, 1'b0, 0, 1, 1'b0);

    // Reset in the middle of fetching, with reads in flight.
    build_model(0, 2, 'h200, 9, 0, 0);
    gidx = 0; lat = 3; gnt_rand = 1'b0; ready_mode = 2;
    cfg_mode = 2'd0; cfg_datasize = 2'd2; cfg_start_addr = AW'('h200);
    cfg_len0 = TS'(9); cfg_len1 = '0; cfg_len2 = '0;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    step();
    step();
    resetn = 1'b0;
    #1;
    check_reset_outs("mid_reset");
    resp_due.delete(); resp_dat.delete(); exp_stream.delete();
    bus.tx_ch_valid_i = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    check_reset_outs("mid_reset_held");
    resetn = 1'b1;

    for (int t = 0; t < 8; t++) begin
      run_xfer("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 'h7FFF)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 'h40)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
               int'($urandom_range(1, 3)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
